ar_tag_allocator: RTL and testbench
===================================

Name: ar_tag_allocator

Overview:
- Sits directly upstream of the outgoing AR request buffer, between the ordering logic's AR source and that buffer.
- Accepts AR requests and assigns each a free internal tag from a fixed pool, then presents the tagged request on a registered AR output.
- Tags return to the pool when the read-response path reports a burst complete.
- Also enforces a per-ID limit on outstanding requests.

Parameters:
- ID_WIDTH, 4: AXI ID width.
- ADDR_WIDTH, 32: address width.
- LEN_WIDTH, 8: burst length width.
- TAG_WIDTH, 4: internal tag width.
- NUM_TAGS, 16: tag pool size. Must be ≤ 2**TAG_WIDTH and ≥ 2.
- MAX_PER_ID, 4: maximum outstanding requests per ID. Range 1..NUM_TAGS.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset. Sampled on posedge clk; 0 means reset.
- in_if  ar_if.receiver  –  AR request in. Uses valid, ready, id, addr, len, size, burst, qos. The incoming tagid is ignored.
- out_if  ar_if.sender  –  tagged AR out to the outgoing request buffer. Drives valid, id, addr, len, size, burst, qos, tagid; samples ready.
- free_valid  input  1  one-cycle pulse; a tag's burst has completed.
- free_tag  input  TAG_WIDTH  tag being released. Qualified by free_valid.
- outstanding  output  TAG_WIDTH+1  number of tags currently allocated.
- err_double_free  output  1  one-cycle registered pulse when a tag that is already free is released.
- stall_cycles  output  32  statistics counter; see Optional Feature.
- alloc_count  output  32  statistics counter; see Optional Feature.

Behaviour:
- State:
  - tag_free[NUM_TAGS] bitmap.
  - tag_owner[NUM_TAGS] table, ID_WIDTH bits per entry.
  - id_cnt[2**ID_WIDTH] counters, $clog2(MAX_PER_ID+1) bits each.
  - One output register stage.
- Reset (rst=0 at posedge):
  - out_if.valid=0 and all out_if payload fields 0.
  - tag_free all 1; id_cnt all 0; outstanding=0; err_double_free=0; stats counters 0.
- Derived signals:
  - can_load = ~out_if.valid | out_if.ready.
  - any_free = OR of tag_free.
  - id_ok = id_cnt[in_if.id] < MAX_PER_ID.
  - alloc_tag = lowest index i with tag_free[i]=1.
- Handshake:
  - in_if.ready = any_free & id_ok & can_load. Combinational; never depends on in_if.valid.
  - Accept when in_if.valid & in_if.ready.
- On accept (next posedge):
  - out_if.valid=1; id/addr/len/size/burst/qos copied from in_if; tagid=alloc_tag zero-extended to TAG_WIDTH.
  - tag_free[alloc_tag]=0; tag_owner[alloc_tag]=in_if.id; id_cnt[in_if.id]+1.
- Latency: exactly 1 cycle from accept to out_if.valid. Full throughput, 1 request/cycle, while the downstream ready is held at 1.
- Output hold: if out_if.valid & ~out_if.ready, all out_if fields are held stable. If out_if.valid & out_if.ready with no new accept, out_if.valid drops to 0 next cycle.
- Release (free_valid=1):
  - If tag_free[free_tag]=0: set tag_free[free_tag]=1 and decrement id_cnt[tag_owner[free_tag]].
  - Otherwise, or if free_tag ≥ NUM_TAGS: no state change, and err_double_free=1 on the next cycle.
- Simultaneous events:
  - Allocation uses the bitmap as it stood before the current cycle's release. A tag freed in cycle N becomes allocatable in N+1.
  - Accept and release on the same ID in one cycle leave id_cnt unchanged.
  - Accept and release of different tags in one cycle leave outstanding unchanged.
- outstanding = NUM_TAGS minus the number of set bits in tag_free, held as a registered counter: +1 on accept, −1 on valid release, net 0 when both occur.
- Pool exhausted (any_free=0): in_if.ready=0. The output register still drains.
- Per-ID limit reached: ready=0 only while in_if.id names that ID. Other IDs still proceed.
- Reset mid-operation: all tags are reclaimed and any pending out_if.valid is dropped. A free_valid in the reset cycle is ignored.

Optional Feature:
- Macro AR_TAG_STATS_EN.
- When defined:
  - stall_cycles increments on every cycle with in_if.valid & ~in_if.ready.
  - alloc_count increments on every accept.
  - Both are 32 bits, wrap modulo 2^32, and are cleared by reset.
- When undefined: both ports are tied to constant 0 and the counter logic is absent.
- Handshake behaviour is identical in both builds.

Test Plan:
- Reset, then 3 back-to-back requests with id=1,2,3 and out_if.ready=1 → tagid 0,1,2 on consecutive cycles, each 1 cycle after accept; outstanding=3.
- 16 requests, each with a distinct id 0..15 (so no per-ID limit applies), with no frees → 17th request sees ready=0. free_tag=5 pulse → the next accept gets tagid=5, one cycle after the free.
- 5 requests all with id=7 (MAX_PER_ID=4) → 5th is stalled while a request with id=8 is accepted. Freeing any id=7 tag → 5th accepted next cycle.
- out_if.ready=0 for 4 cycles with a request pending → out_if fields stable; in_if.ready=0 after the first accept. Raise ready → one transfer, then the next request proceeds.
- Free of tag 3 while it is already free → err_double_free pulses 1 cycle later; outstanding unchanged. Accept and free on the same id in one cycle → id_cnt unchanged.
- Assert rst=0 with 6 tags outstanding and out_if.valid=1 → next cycle outstanding=0, out_if.valid=0, and the next accept gets tagid=0. With AR_TAG_STATS_EN, 10 stall cycles → stall_cycles=10.

Source files
------------

// File: rtl/ar_tag_allocator_if.sv
// AR channel bundle between the ordering logic, the tag allocator and the outgoing request buffer.
interface ar_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned TAG_WIDTH  = 4
) ();
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  len;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic [3:0]            qos;
  logic [TAG_WIDTH-1:0]  tagid;

  modport sender (output valid, id, addr, len, size, burst, qos, tagid, input ready);
  modport receiver (input valid, id, addr, len, size, burst, qos, tagid, output ready);
endinterface

// File: rtl/ar_tag_allocator.sv
// Assigns a free internal tag to each AR request, enforces a per-ID outstanding limit and
// registers the tagged request. Optional statistics counters are enabled by AR_TAG_STATS_EN.
module ar_tag_allocator #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned NUM_TAGS   = 16,
  parameter int unsigned MAX_PER_ID = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ar_if.receiver               in_if,
  ar_if.sender                 out_if,
  input  logic                 free_valid,
  input  logic [TAG_WIDTH-1:0] free_tag,
  output logic [TAG_WIDTH:0]   outstanding,
  output logic                 err_double_free,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          alloc_count
);

  localparam int unsigned NumIds = 2 ** ID_WIDTH;
  localparam int unsigned CntW   = $clog2(MAX_PER_ID + 1);

  localparam logic [CntW-1:0]    MaxCnt   = CntW'(MAX_PER_ID);
  localparam logic [CntW-1:0]    CntOne   = CntW'(1);
  localparam logic [TAG_WIDTH:0] NumTagsW = (TAG_WIDTH + 1)'(NUM_TAGS);
  localparam logic [TAG_WIDTH:0] OutOne   = (TAG_WIDTH + 1)'(1);

  logic [NUM_TAGS-1:0] tag_free_q, tag_free_d;
  logic [ID_WIDTH-1:0] tag_owner_q [NUM_TAGS];
  logic [CntW-1:0]     id_cnt_q [NumIds];
  logic [CntW-1:0]     id_cnt_d [NumIds];
  logic [TAG_WIDTH:0]  outstanding_q, outstanding_d;
  logic                err_q;

  logic                  out_valid_q;
  logic [ID_WIDTH-1:0]   out_id_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [LEN_WIDTH-1:0]  out_len_q;
  logic [2:0]            out_size_q;
  logic [1:0]            out_burst_q;
  logic [3:0]            out_qos_q;
  logic [TAG_WIDTH-1:0]  out_tag_q;

  logic [TAG_WIDTH-1:0] alloc_tag;
  logic [ID_WIDTH-1:0]  free_owner;
  logic any_free, id_ok, can_load, accept, free_in_range, free_hit;
  logic unused_tagid;

  assign unused_tagid  = ^in_if.tagid;
  assign any_free      = |tag_free_q;
  assign id_ok         = id_cnt_q[in_if.id] < MaxCnt;
  assign can_load      = ~out_valid_q | out_if.ready;
  assign in_if.ready   = any_free & id_ok & can_load;
  assign accept        = in_if.valid & in_if.ready;
  assign free_in_range = {1'b0, free_tag} < NumTagsW;
  assign free_hit      = free_valid & free_in_range & ~tag_free_q[free_tag];
  assign free_owner    = tag_owner_q[free_tag];

  // Lowest-index free tag wins.
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (tag_free_q[i]) alloc_tag = TAG_WIDTH'(i);
    end
  end

  // A valid release always names an allocated tag, so it never collides with alloc_tag.
  always_comb begin
    tag_free_d    = tag_free_q;
    id_cnt_d      = id_cnt_q;
    outstanding_d = outstanding_q;
    if (accept) begin
      tag_free_d[alloc_tag] = 1'b0;
      id_cnt_d[in_if.id]    = id_cnt_d[in_if.id] + CntOne;
      outstanding_d         = outstanding_d + OutOne;
    end
    if (free_hit) begin
      tag_free_d[free_tag]  = 1'b1;
      id_cnt_d[free_owner]  = id_cnt_d[free_owner] - CntOne;
      outstanding_d         = outstanding_d - OutOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_free_q    <= '1;
      id_cnt_q      <= '{default: '0};
      outstanding_q <= '0;
      err_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_id_q      <= '0;
      out_addr_q    <= '0;
      out_len_q     <= '0;
      out_size_q    <= '0;
      out_burst_q   <= '0;
      out_qos_q     <= '0;
      out_tag_q     <= '0;
    end else begin
      tag_free_q    <= tag_free_d;
      id_cnt_q      <= id_cnt_d;
      outstanding_q <= outstanding_d;
      err_q         <= free_valid & ~free_hit;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_id_q    <= in_if.id;
        out_addr_q  <= in_if.addr;
        out_len_q   <= in_if.len;
        out_size_q  <= in_if.size;
        out_burst_q <= in_if.burst;
        out_qos_q   <= in_if.qos;
        out_tag_q   <= alloc_tag;
      end else if (out_if.ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Owner entries are only read for allocated tags, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) tag_owner_q[alloc_tag] <= in_if.id;
  end

  assign out_if.valid    = out_valid_q;
  assign out_if.id       = out_id_q;
  assign out_if.addr     = out_addr_q;
  assign out_if.len      = out_len_q;
  assign out_if.size     = out_size_q;
  assign out_if.burst    = out_burst_q;
  assign out_if.qos      = out_qos_q;
  assign out_if.tagid    = out_tag_q;
  assign outstanding     = outstanding_q;
  assign err_double_free = err_q;

`ifdef AR_TAG_STATS_EN
  logic [31:0] stall_cycles_q, alloc_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      alloc_count_q  <= '0;
    end else begin
      if (in_if.valid & ~in_if.ready) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (accept) alloc_count_q <= alloc_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign alloc_count  = alloc_count_q;
`else
  assign stall_cycles = '0;
  assign alloc_count  = '0;
`endif

endmodule

// File: tb/tb_ar_tag_allocator.sv
// Randomized and directed bench for ar_tag_allocator against a bitmap/queue-level reference model.
module tb_ar_tag_allocator;
  localparam int IdW = 4, AddrW = 32, LenW = 8, TagW = 4, NTags = 16, MaxPerId = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            free_valid;
  logic [TagW-1:0] free_tag;
  logic [TagW:0]   outstanding;
  logic            err_double_free;
  logic [31:0]     stall_cycles, alloc_count;

  ar_if #(.ID_WIDTH(IdW), .ADDR_WIDTH(AddrW), .LEN_WIDTH(LenW), .TAG_WIDTH(TagW)) in_bus ();
  ar_if #(.ID_WIDTH(IdW), .ADDR_WIDTH(AddrW), .LEN_WIDTH(LenW), .TAG_WIDTH(TagW)) out_bus ();

  ar_tag_allocator #(
    .ID_WIDTH(IdW), .ADDR_WIDTH(AddrW), .LEN_WIDTH(LenW), .TAG_WIDTH(TagW),
    .NUM_TAGS(NTags), .MAX_PER_ID(MaxPerId)
  ) dut (
    .clk(clk), .rst(rst), .in_if(in_bus), .out_if(out_bus),
    .free_valid(free_valid), .free_tag(free_tag), .outstanding(outstanding),
    .err_double_free(err_double_free), .stall_cycles(stall_cycles), .alloc_count(alloc_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_free  [NTags];
  int          m_owner [NTags];
  int          m_cnt   [16];
  bit          m_ov;
  logic [3:0]  m_id, m_tag, m_qos;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  bit          m_err;
  int unsigned m_stall, m_alloc;

  task automatic model_reset();
    for (int i = 0; i < NTags; i++) m_free[i] = 1'b1;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_ov = 0; m_id = '0; m_tag = '0; m_qos = '0; m_addr = '0; m_len = '0;
    m_size = '0; m_burst = '0; m_err = 0; m_stall = 0; m_alloc = 0;
  endtask

  function automatic int model_outstanding();
    int n = 0;
    for (int i = 0; i < NTags; i++) if (!m_free[i]) n++;
    return n;
  endfunction

  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst = 1'b0;
      in_bus.valid = 1'b0;
      out_bus.ready = 1'($urandom);
      free_valid = 1'b1;
      free_tag = TagW'($urandom);
      #1;
    end
    model_reset();
  endtask

  task automatic step(input bit v, input int id, input bit ordy, input bit fv, input int ft);
    bit exp_ready, any_free, acc, rel;
    int lowest;
    @(negedge clk);
    rst = 1'b1;
    in_bus.valid = v;
    in_bus.id    = IdW'(id);
    in_bus.addr  = $urandom;
    in_bus.len   = LenW'($urandom);
    in_bus.size  = 3'($urandom);
    in_bus.burst = 2'($urandom);
    in_bus.qos   = 4'($urandom);
    in_bus.tagid = TagW'($urandom);
    out_bus.ready = ordy;
    free_valid = fv;
    free_tag = TagW'(ft);
    #1;
    any_free = model_outstanding() < NTags;
    exp_ready = any_free && (m_cnt[id] < MaxPerId) && (!m_ov || ordy);
    check_eq("in_ready", in_bus.ready, exp_ready);
    check_eq("out_valid", out_bus.valid, m_ov);
    check_eq("out_id", out_bus.id, m_id);
    check_eq("out_addr", out_bus.addr, m_addr);
    check_eq("out_len", out_bus.len, m_len);
    check_eq("out_size", out_bus.size, m_size);
    check_eq("out_burst", out_bus.burst, m_burst);
    check_eq("out_qos", out_bus.qos, m_qos);
    check_eq("out_tagid", out_bus.tagid, m_tag);
    check_eq("outstanding", outstanding, model_outstanding());
    check_eq("err_double_free", err_double_free, m_err);
`ifdef AR_TAG_STATS_EN
    check_eq("stall_cycles", stall_cycles, m_stall);
    check_eq("alloc_count", alloc_count, m_alloc);
`else
    check_eq("stall_cycles", stall_cycles, 0);
    check_eq("alloc_count", alloc_count, 0);
`endif
    acc = v && exp_ready;
    lowest = -1;
    for (int i = 0; i < NTags; i++) if (m_free[i] && lowest < 0) lowest = i;
    rel = fv && (ft < NTags) && !m_free[ft];
    m_err = fv && !rel;
    if (v && !exp_ready) m_stall++;
    if (acc) begin
      m_alloc++;
      m_ov = 1; m_id = in_bus.id; m_addr = in_bus.addr; m_len = in_bus.len;
      m_size = in_bus.size; m_burst = in_bus.burst; m_qos = in_bus.qos; m_tag = 4'(lowest);
      m_free[lowest] = 0; m_owner[lowest] = id; m_cnt[id]++;
    end else if (ordy) begin
      m_ov = 0;
    end
    if (rel) begin
      m_free[ft] = 1;
      m_cnt[m_owner[ft]]--;
    end
  endtask

  function automatic int pick_free_tag();
    int cand [$];
    for (int i = 0; i < NTags; i++) if (!m_free[i]) cand.push_back(i);
    if (cand.size() == 0 || $urandom_range(0, 3) == 0) return $urandom_range(0, NTags - 1);
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  initial begin
    rst = 1'b0; free_valid = 1'b0; free_tag = '0;
    in_bus.valid = 1'b0; in_bus.id = '0; in_bus.addr = '0; in_bus.len = '0;
    in_bus.size = '0; in_bus.burst = '0; in_bus.qos = '0; in_bus.tagid = '0;
    out_bus.ready = 1'b1;

    // Back-to-back tagging
    do_reset(2);
    step(1, 1, 1, 0, 0);
    check_eq("rst_outstanding", outstanding, 0);
    step(1, 2, 1, 0, 0);
    step(1, 3, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_eq("b2b_last_tag", out_bus.tagid, 2);
    check_eq("b2b_outstanding", outstanding, 3);

    // Pool exhaustion and reuse of a freed tag
    do_reset(1);
    for (int i = 0; i < 16; i++) step(1, i, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    check_eq("full_ready", in_bus.ready, 0);
    step(1, 0, 1, 1, 5);
    check_eq("free_same_cycle_ready", in_bus.ready, 0);
    step(1, 0, 1, 0, 0);
    check_eq("after_free_ready", in_bus.ready, 1);
    step(0, 0, 1, 0, 0);
    check_eq("reuse_tag5", out_bus.tagid, 5);

    // Per-ID limit
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1, 7, 1, 0, 0);
    step(1, 7, 1, 0, 0);
    check_eq("id7_limited", in_bus.ready, 0);
    step(1, 8, 1, 0, 0);
    check_eq("id8_passes", in_bus.ready, 1);
    step(1, 7, 1, 1, 0);
    step(1, 7, 1, 0, 0);
    check_eq("id7_after_free", in_bus.ready, 1);
    step(0, 0, 1, 0, 0);

    // Output backpressure
    do_reset(1);
    step(1, 2, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 3, 0, 0, 0);
    check_eq("bp_ready_low", in_bus.ready, 0);
    step(1, 3, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_eq("bp_second_tag", out_bus.tagid, 1);

    // Double free and same-ID accept/release
    do_reset(1);
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 1, 3);
    step(0, 0, 1, 0, 0);
    check_eq("dbl_free_err", err_double_free, 1);
    check_eq("dbl_free_outstanding", outstanding, 1);
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
    check_eq("same_id_limit", in_bus.ready, 0);

    // Reset mid-operation
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1, i, 1, 0, 0);
    do_reset(1);
    step(1, 9, 1, 0, 0);
    check_eq("midrst_valid", out_bus.valid, 0);
    check_eq("midrst_outstanding", outstanding, 0);
    step(0, 0, 1, 0, 0);
    check_eq("midrst_tag0", out_bus.tagid, 0);

    // Stall counting
    do_reset(1);
    step(1, 2, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0);
`ifdef AR_TAG_STATS_EN
    check_eq("stall_10", stall_cycles, 10);
`else
    check_eq("stall_off", stall_cycles, 0);
`endif

    // Randomized traffic
    do_reset(1);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset(1);
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 3), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 4), pick_free_tag());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
